// File: rtl/link_pair_serializer.sv
// rtl/link_pair_serializer.sv - multi-pair symbol serializer with training and idle fill
module link_pair_serializer #(
    parameter int PAIRS = 4,
    parameter int SYMBOL_BITS = 8,
    parameter int TRAIN_LEN = 16,
    parameter logic [SYMBOL_BITS-1:0] TRAIN_PATTERN = 8'h55,
    parameter logic [SYMBOL_BITS-1:0] IDLE_SYMBOL = 8'hA5
) (
    input  logic                         Clock100Mhz,
    input  logic                         Reset,
    input  logic [PAIRS-1:0]             PairEnable,
    input  logic                         Train,
    input  logic [PAIRS*SYMBOL_BITS-1:0] InData,
    input  logic                         InValid,
    output logic                         InReady,
    output logic [PAIRS-1:0]             PairOut,
    output logic                         FrameSync,
    output logic                         Training,
    output logic                         IdleInserted
);

    localparam int BW = $clog2(SYMBOL_BITS);
    localparam int SW = (TRAIN_LEN > 1) ? $clog2(TRAIN_LEN) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(SYMBOL_BITS - 1);
    localparam logic [SW-1:0] LAST_SYM = SW'(TRAIN_LEN - 1);

    typedef enum logic {
        TRAIN_ST,
        RUN_ST
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [BW-1:0]          bit_count;
    logic [SW-1:0]          sym_count;
    logic [SW-1:0]          sym_next;
    logic [PAIRS-1:0]       en_mask;
    logic [SYMBOL_BITS-1:0] lane_shift [PAIRS];
    logic [SYMBOL_BITS-1:0] lane_next  [PAIRS];

    logic                   boundary;
    logic                   transfer;
    logic                   load_train;
    logic                   load_mask;
    logic                   idle_next;
    logic [SW-1:0]          train_index;
    logic [SYMBOL_BITS-1:0] train_symbol;
    logic                   frame_sync_q;
    logic                   training_q;
    logic                   idle_q;

    assign boundary = (bit_count == LAST_BIT);
    assign InReady  = (state == RUN_ST) && boundary && !Train;
    assign transfer = InReady && InValid;

    // A RUN boundary with Train pending restarts training at symbol 0.
    always_comb begin
        state_next  = state;
        sym_next    = sym_count;
        load_train  = 1'b0;
        train_index = sym_count;
        if (boundary) begin
            case (state)
                TRAIN_ST: begin
                    load_train  = 1'b1;
                    train_index = sym_count;
                end
                RUN_ST: begin
                    if (Train) begin
                        load_train  = 1'b1;
                        train_index = '0;
                    end
                end
                default: begin
                    load_train  = 1'b1;
                    train_index = '0;
                end
            endcase
            if (load_train) begin
                if (train_index == LAST_SYM) begin
                    state_next = RUN_ST;
                    sym_next   = '0;
                end else begin
                    state_next = TRAIN_ST;
                    sym_next   = train_index + SW'(1);
                end
            end
        end
    end

    always_comb begin
        train_symbol = train_index[0] ? ~TRAIN_PATTERN : TRAIN_PATTERN;
        load_mask    = load_train && (train_index == '0);
        idle_next    = boundary && !load_train && !transfer;
    end

    always_comb begin
        for (int i = 0; i < PAIRS; i++) begin
            lane_next[i] = {lane_shift[i][SYMBOL_BITS-2:0], 1'b0};
            if (boundary) begin
                if (load_train) begin
                    lane_next[i] = train_symbol;
                end else if (transfer) begin
                    lane_next[i] = InData[i*SYMBOL_BITS +: SYMBOL_BITS];
                end else begin
                    lane_next[i] = IDLE_SYMBOL;
                end
            end
        end
    end

    always_ff @(posedge Clock100Mhz) begin
        if (Reset) begin
            state        <= TRAIN_ST;
            sym_count    <= '0;
            bit_count    <= LAST_BIT;
            en_mask      <= '0;
            frame_sync_q <= 1'b0;
            training_q   <= 1'b0;
            idle_q       <= 1'b0;
            for (int i = 0; i < PAIRS; i++) begin
                lane_shift[i] <= '0;
            end
        end else begin
            state        <= state_next;
            sym_count    <= sym_next;
            frame_sync_q <= boundary;
            for (int i = 0; i < PAIRS; i++) begin
                lane_shift[i] <= lane_next[i];
            end
            if (boundary) begin
                bit_count  <= '0;
                training_q <= load_train;
                idle_q     <= idle_next;
                if (load_mask) begin
                    en_mask <= PairEnable;
                end
            end else begin
                bit_count <= bit_count + BW'(1);
            end
        end
    end

    // Disabled lanes still shift internally; only the line is forced low.
    always_comb begin
        PairOut = '0;
        for (int i = 0; i < PAIRS; i++) begin
            PairOut[i] = lane_shift[i][SYMBOL_BITS-1] & en_mask[i];
        end
    end

    assign FrameSync    = frame_sync_q;
    assign Training     = training_q;
    assign IdleInserted = idle_q;

endmodule

// File: tb/tb_link_pair_serializer.sv
// tb/tb_link_pair_serializer.sv - directed vector bench for link_pair_serializer
module tb_link_pair_serializer;

    logic        clk;
    logic        rst;
    logic [3:0]  pair_enable;
    logic        train;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  pair_out;
    logic        frame_sync;
    logic        training;
    logic        idle_inserted;

    int checks;
    int failures;

    link_pair_serializer #(
        .PAIRS(4),
        .SYMBOL_BITS(8),
        .TRAIN_LEN(4),
        .TRAIN_PATTERN(8'h55),
        .IDLE_SYMBOL(8'hA5)
    ) dut (
        .Clock100Mhz(clk),
        .Reset(rst),
        .PairEnable(pair_enable),
        .Train(train),
        .InData(in_data),
        .InValid(in_valid),
        .InReady(in_ready),
        .PairOut(pair_out),
        .FrameSync(frame_sync),
        .Training(training),
        .IdleInserted(idle_inserted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_reset;
        logic [3:0]  pen;
        logic        valid;
        logic [31:0] data;
        logic        trn;
        logic        exp_ready;
        logic [31:0] exp_lanes;
        logic        exp_tr;
        logic        exp_idle;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] p, input logic v, input logic [31:0] d,
                       input logic t, input logic er, input logic [31:0] el, input logic etr,
                       input logic eid);
        vec_t x;
        x.do_reset = r; x.pen = p; x.valid = v; x.data = d; x.trn = t;
        x.exp_ready = er; x.exp_lanes = el; x.exp_tr = etr; x.exp_idle = eid;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic apply_reset(input string name, input logic [3:0] pen);
        rst = 1'b1;
        in_valid = 1'b0;
        train = 1'b0;
        pair_enable = pen;
        repeat (3) @(posedge clk);
        #1;
        check({name, ".reset_out"},
              {24'd0, pair_out, in_ready, frame_sync, training, idle_inserted}, 32'd0);
        rst = 1'b0;
    endtask

    // Captures one full symbol period starting at the next (boundary) edge.
    task automatic run_symbol(input string name, input logic [31:0] exp_lanes,
                              input logic exp_tr, input logic exp_idle);
        logic [31:0] got;
        logic fs_bad, tr_bad, idle_bad, rdy_bad;
        got = '0; fs_bad = 0; tr_bad = 0; idle_bad = 0; rdy_bad = 0;
        for (int b = 0; b < 8; b++) begin
            @(posedge clk);
            #1;
            for (int l = 0; l < 4; l++) got[l*8 + 7 - b] = pair_out[l];
            if (frame_sync !== (b == 0)) fs_bad = 1;
            if (training !== exp_tr) tr_bad = 1;
            if (idle_inserted !== exp_idle) idle_bad = 1;
            if (b < 7 && in_ready !== 1'b0) rdy_bad = 1;
        end
        check({name, ".lanes"}, got, exp_lanes);
        check({name, ".framesync"}, {31'd0, fs_bad}, 32'd0);
        check({name, ".training"}, {31'd0, tr_bad}, 32'd0);
        check({name, ".idle"}, {31'd0, idle_bad}, 32'd0);
        check({name, ".ready_mid"}, {31'd0, rdy_bad}, 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        int n;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        pair_enable = 4'h0;
        train = 1'b0;
        in_data = '0;
        in_valid = 1'b0;

        // Bring-up with all pairs, idle fill, continuous data, alternating valid
        add(1, 4'hF, 0, 32'h0,        0, 0, 32'h55555555, 1, 0);
        add(0, 4'hF, 0, 32'h0,        0, 0, 32'hAAAAAAAA, 1, 0);
        add(0, 4'hF, 0, 32'h0,        0, 0, 32'h55555555, 1, 0);
        add(0, 4'hF, 0, 32'h0,        0, 0, 32'hAAAAAAAA, 1, 0);
        add(0, 4'hF, 0, 32'h0,        0, 1, 32'hA5A5A5A5, 0, 1);
        add(0, 4'hF, 1, 32'h11223344, 0, 1, 32'h11223344, 0, 0);
        add(0, 4'hF, 1, 32'h11223344, 0, 1, 32'h11223344, 0, 0);
        add(0, 4'hF, 1, 32'h11223344, 0, 1, 32'h11223344, 0, 0);
        add(0, 4'hF, 0, 32'h0,        0, 1, 32'hA5A5A5A5, 0, 1);
        add(0, 4'hF, 1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0);
        add(0, 4'hF, 0, 32'h0,        0, 1, 32'hA5A5A5A5, 0, 1);
        add(0, 4'hF, 1, 32'h0F1E2D3C, 0, 1, 32'h0F1E2D3C, 0, 0);
        // All-zero mask: normal sequencing, silent lines
        add(1, 4'h0, 0, 32'h0,        0, 0, 32'h00000000, 1, 0);
        add(0, 4'h0, 0, 32'h0,        0, 0, 32'h00000000, 1, 0);
        add(0, 4'h0, 0, 32'h0,        0, 0, 32'h00000000, 1, 0);
        add(0, 4'h0, 0, 32'h0,        0, 0, 32'h00000000, 1, 0);
        add(0, 4'h0, 1, 32'hFFFFFFFF, 0, 1, 32'h00000000, 0, 0);
        // Partial mask, mask change only takes effect at re-training
        add(1, 4'h5, 0, 32'h0,        0, 0, 32'h00550055, 1, 0);
        add(0, 4'h5, 0, 32'h0,        0, 0, 32'h00AA00AA, 1, 0);
        add(0, 4'h5, 0, 32'h0,        0, 0, 32'h00550055, 1, 0);
        add(0, 4'h5, 0, 32'h0,        0, 0, 32'h00AA00AA, 1, 0);
        add(0, 4'hF, 1, 32'h11223344, 0, 1, 32'h00220044, 0, 0);
        add(0, 4'hF, 1, 32'h11223344, 1, 0, 32'h55555555, 1, 0);
        add(0, 4'hF, 0, 32'h0,        0, 0, 32'hAAAAAAAA, 1, 0);
        add(0, 4'hF, 0, 32'h0,        0, 0, 32'h55555555, 1, 0);
        add(0, 4'hF, 0, 32'h0,        0, 0, 32'hAAAAAAAA, 1, 0);
        add(0, 4'hF, 1, 32'h11223344, 0, 1, 32'h11223344, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) apply_reset($sformatf("vec%0d", i), vecs[i].pen);
            pair_enable = vecs[i].pen;
            in_valid = vecs[i].valid;
            in_data = vecs[i].data;
            train = vecs[i].trn;
            #1;
            check($sformatf("vec%0d.ready", i), {31'd0, in_ready}, {31'd0, vecs[i].exp_ready});
            run_symbol($sformatf("vec%0d", i), vecs[i].exp_lanes, vecs[i].exp_tr,
                       vecs[i].exp_idle);
        end

        // Train raised at bit 3 of a data symbol
        in_valid = 1'b1;
        in_data = 32'h11223344;
        train = 1'b0;
        #1;
        check("seqA.ready_pre", {31'd0, in_ready}, 32'd1);
        got = '0;
        for (int b = 0; b < 8; b++) begin
            @(posedge clk);
            #1;
            for (int l = 0; l < 4; l++) got[l*8 + 7 - b] = pair_out[l];
            if (b == 3) train = 1'b1;
        end
        in_data = 32'hCAFEF00D;
        #1;
        check("seqA.completes", got, 32'h11223344);
        check("seqA.ready_boundary", {31'd0, in_ready}, 32'd0);
        run_symbol("seqA.train0", 32'h55555555, 1, 0);
        train = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("seqA.ready_wait", n, 24);
        run_symbol("seqA.accept", 32'hCAFEF00D, 0, 0);

        // Reset asserted at bit 5 of a data symbol
        in_valid = 1'b1;
        in_data = 32'hFFFFFFFF;
        for (int b = 0; b < 6; b++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("seqB.reset_out",
              {24'd0, pair_out, in_ready, frame_sync, training, idle_inserted}, 32'd0);
        rst = 1'b0;
        run_symbol("seqB.t0", 32'h55555555, 1, 0);
        run_symbol("seqB.t1", 32'hAAAAAAAA, 1, 0);
        run_symbol("seqB.t2", 32'h55555555, 1, 0);
        run_symbol("seqB.t3", 32'hAAAAAAAA, 1, 0);
        check("seqB.ready", {31'd0, in_ready}, 32'd1);
        run_symbol("seqB.data", 32'hFFFFFFFF, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
